// File: rtl/dma_job_arbiter_if.sv
// dma_job_arbiter_if
// Bundles the job-request handshake of two requesters and the DMA register
// write port that the arbiter drives.
//   master : arbiter side (consumes requests and dma_busy, drives everything else)
//   slave  : requester/DMA side (mirror image of master)
// Signals:
//   req_valid/req_cols/req_rows/req_set/req_addr : packed per-requester job fields
//   req_ready/job_done/job_err                   : one-cycle pulses per requester
//   dma_write/dma_data/dma_select                : DMA register write strobe, data, index
//   dma_busy                                     : DMA busy flag
//   ctl_busy/grant_id                            : arbiter activity and current owner
interface dma_job_arbiter_if #(
  parameter int DATAWIDTH = 8
);
  logic [1:0]             req_valid;
  logic [2*DATAWIDTH-1:0] req_cols;
  logic [2*DATAWIDTH-1:0] req_rows;
  logic [3:0]             req_set;
  logic [2*DATAWIDTH-1:0] req_addr;
  logic [1:0]             req_ready;
  logic [1:0]             job_done;
  logic [1:0]             job_err;
  logic                   dma_write;
  logic [DATAWIDTH-1:0]   dma_data;
  logic [2:0]             dma_select;
  logic                   dma_busy;
  logic                   ctl_busy;
  logic                   grant_id;

  modport master (
    input  req_valid, req_cols, req_rows, req_set, req_addr, dma_busy,
    output req_ready, job_done, job_err, dma_write, dma_data, dma_select,
           ctl_busy, grant_id
  );

  modport slave (
    output req_valid, req_cols, req_rows, req_set, req_addr, dma_busy,
    input  req_ready, job_done, job_err, dma_write, dma_data, dma_select,
           ctl_busy, grant_id
  );
endinterface

// File: rtl/dma_job_arbiter.sv
// dma_job_arbiter
// Arbitrates two job requesters onto one DMA engine. An accepted job is
// range-checked, programmed into the DMA with five register writes (cols,
// rows, set, addr, then the start register), and then tracked until the DMA
// goes busy and idle again. Bad jobs and DMA start timeouts end in an error
// pulse to the owning requester. Arbitration is round-robin.
// Ports:
//   clk : clock
//   rst : synchronous active-high reset (shared with the DMA)
//   bus : dma_job_arbiter_if.master (request handshake, DMA write port, status)
// All outputs come straight from registers.
module dma_job_arbiter #(
  parameter int DATAWIDTH   = 8,
  parameter int ARM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  dma_job_arbiter_if.master bus
);

  localparam int DW = DATAWIDTH;
  localparam int WW = 2 * DW + 1;
  localparam int CW = (ARM_TIMEOUT < 1) ? 1 : $clog2(ARM_TIMEOUT + 1);

  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ARM_TIMEOUT - 1);
  localparam logic [DW-1:0] DATA_ONE = DW'(1'b1);
  localparam logic [WW-1:0] WIDE_ONE = WW'(1'b1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ARM  = 3'd2,
    RUN  = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

  // A job fits when it is non-empty and its last byte (addr + rows*cols - 1)
  // stays inside the DW-bit address space; computed wide so nothing wraps.
  function automatic logic job_fits(input logic [DW-1:0] cols,
                                    input logic [DW-1:0] rows,
                                    input logic [DW-1:0] addr);
    logic [WW-1:0] span;
    logic [WW-1:0] last;
    span = WW'(cols) * WW'(rows);
    last = WW'(addr) + span - WIDE_ONE;
    if ((cols == {DW{1'b0}}) || (rows == {DW{1'b0}})) begin
      job_fits = 1'b0;
    end else begin
      job_fits = (last[WW-1:DW] == {(WW-DW){1'b0}});
    end
  endfunction

  state_t          state_q, state_d;
  logic [2:0]      step_q, step_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            grant_q, grant_d;
  logic            last_q, last_d;
  logic [DW-1:0]   cols_q, cols_d;
  logic [DW-1:0]   rows_q, rows_d;
  logic [DW-1:0]   addr_q, addr_d;
  logic [1:0]      set_q, set_d;
  logic            fits_q, fits_d;
  logic [1:0]      req_ready_q, req_ready_d;
  logic [1:0]      job_done_q, job_done_d;
  logic [1:0]      job_err_q, job_err_d;
  logic            dma_write_q, dma_write_d;
  logic [DW-1:0]   dma_data_q, dma_data_d;
  logic [2:0]      dma_select_q, dma_select_d;
  logic            ctl_busy_q, ctl_busy_d;

  logic            win_s;
  logic [1:0]      grant_oh_s;
  logic [DW-1:0]   sel_cols_s;
  logic [DW-1:0]   sel_rows_s;
  logic [DW-1:0]   sel_addr_s;
  logic [1:0]      sel_set_s;

  // Round-robin pick: a lone requester wins outright, contention goes to the
  // requester that was not served last.
  always_comb begin
    if (bus.req_valid == 2'b11) begin
      win_s = ~last_q;
    end else if (bus.req_valid == 2'b10) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
  end

  assign sel_cols_s = win_s ? bus.req_cols[2*DW-1:DW] : bus.req_cols[DW-1:0];
  assign sel_rows_s = win_s ? bus.req_rows[2*DW-1:DW] : bus.req_rows[DW-1:0];
  assign sel_addr_s = win_s ? bus.req_addr[2*DW-1:DW] : bus.req_addr[DW-1:0];
  assign sel_set_s  = win_s ? bus.req_set[3:2]        : bus.req_set[1:0];
  assign grant_oh_s = grant_q ? 2'b10 : 2'b01;

  // Next-state and next-output logic; every output pulse is decided one
  // cycle ahead so it can be registered together with the state.
  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    last_d       = last_q;
    cols_d       = cols_q;
    rows_d       = rows_q;
    addr_d       = addr_q;
    set_d        = set_q;
    fits_d       = fits_q;
    req_ready_d  = 2'b00;
    job_done_d   = 2'b00;
    job_err_d    = 2'b00;
    dma_write_d  = 1'b0;
    dma_data_d   = {DW{1'b0}};
    dma_select_d = 3'd0;

    case (state_q)
      IDLE: begin
        // The DMA may still be finishing work started before a reset.
        if (!bus.dma_busy && (bus.req_valid != 2'b00)) begin
          grant_d     = win_s;
          cols_d      = sel_cols_s;
          rows_d      = sel_rows_s;
          addr_d      = sel_addr_s;
          set_d       = sel_set_s;
          fits_d      = job_fits(sel_cols_s, sel_rows_s, sel_addr_s);
          req_ready_d = win_s ? 2'b10 : 2'b01;
          step_d      = 3'd0;
          state_d     = LOAD;
        end else begin
          state_d = IDLE;
        end
      end

      LOAD: begin
        // Step 0 is the acceptance cycle: a rejected job leaves before any
        // register is touched. Steps 0..4 queue the five writes, step 5 is
        // the cycle the start write is on the bus.
        if (!fits_q) begin
          job_err_d = grant_oh_s;
          state_d   = ERR;
        end else if (step_q == 3'd5) begin
          cnt_d   = {CW{1'b0}};
          state_d = ARM;
        end else begin
          dma_write_d = 1'b1;
          step_d      = step_q + 3'd1;
          case (step_q)
            3'd0: begin
              dma_select_d = 3'd0;
              dma_data_d   = cols_q;
            end
            3'd1: begin
              dma_select_d = 3'd1;
              dma_data_d   = rows_q;
            end
            3'd2: begin
              dma_select_d = 3'd2;
              dma_data_d   = DW'(set_q);
            end
            3'd3: begin
              dma_select_d = 3'd4;
              dma_data_d   = addr_q;
            end
            3'd4: begin
              dma_select_d = 3'd3;
              dma_data_d   = DATA_ONE;
            end
            default: begin
              dma_select_d = 3'd0;
              dma_data_d   = {DW{1'b0}};
            end
          endcase
        end
      end

      ARM: begin
        // cnt_q counts completed ARM cycles; the last allowed one is
        // ARM_TIMEOUT-1, after which the job is abandoned.
        if (bus.dma_busy) begin
          state_d = RUN;
        end else if (cnt_q == CNT_LAST) begin
          job_err_d = grant_oh_s;
          state_d   = ERR;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      RUN: begin
        if (!bus.dma_busy) begin
          job_done_d = grant_oh_s;
          state_d    = DONE;
        end else begin
          state_d = RUN;
        end
      end

      DONE: begin
        last_d  = grant_q;
        state_d = IDLE;
      end

      ERR: begin
        last_d  = grant_q;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    ctl_busy_d = (state_d != IDLE);
  end

  // State, job context and output registers. Reset parks the round-robin
  // pointer on requester 1 so requester 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      step_q       <= 3'd0;
      cnt_q        <= {CW{1'b0}};
      grant_q      <= 1'b0;
      last_q       <= 1'b1;
      cols_q       <= {DW{1'b0}};
      rows_q       <= {DW{1'b0}};
      addr_q       <= {DW{1'b0}};
      set_q        <= 2'b00;
      fits_q       <= 1'b0;
      req_ready_q  <= 2'b00;
      job_done_q   <= 2'b00;
      job_err_q    <= 2'b00;
      dma_write_q  <= 1'b0;
      dma_data_q   <= {DW{1'b0}};
      dma_select_q <= 3'd0;
      ctl_busy_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      last_q       <= last_d;
      cols_q       <= cols_d;
      rows_q       <= rows_d;
      addr_q       <= addr_d;
      set_q        <= set_d;
      fits_q       <= fits_d;
      req_ready_q  <= req_ready_d;
      job_done_q   <= job_done_d;
      job_err_q    <= job_err_d;
      dma_write_q  <= dma_write_d;
      dma_data_q   <= dma_data_d;
      dma_select_q <= dma_select_d;
      ctl_busy_q   <= ctl_busy_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.job_done   = job_done_q;
  assign bus.job_err    = job_err_q;
  assign bus.dma_write  = dma_write_q;
  assign bus.dma_data   = dma_data_q;
  assign bus.dma_select = dma_select_q;
  assign bus.ctl_busy   = ctl_busy_q;
  assign bus.grant_id   = grant_q;

endmodule

// File: tb/tb_dma_job_arbiter.sv
// tb_dma_job_arbiter
// Scoreboard bench: stimulus pushes the expected output events (with the
// required cycle gap to the previous event) into a queue; a monitor pops and
// compares each time the DUT pulses req_ready, dma_write, job_done or job_err.
// A small DMA model raises dma_busy one cycle after the start write and
// holds it for HOLD cycles.
module tb_dma_job_arbiter;
  localparam int DW   = 8;
  localparam int TO   = 16;
  localparam int HOLD = 3;
  localparam int K_READY = 0;
  localparam int K_WRITE = 1;
  localparam int K_DONE  = 2;
  localparam int K_ERR   = 3;

  typedef struct {
    int kind;
    int val;
    int gap;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dma_job_arbiter_if #(.DATAWIDTH(DW)) bus ();

  dma_job_arbiter #(.DATAWIDTH(DW), .ARM_TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t exp_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   cyc = 0;
  int   last_ev_cyc = 0;
  bit   dma_auto = 1'b1;
  bit   dma_force = 1'b0;
  bit   pending = 1'b0;
  int   hold_left = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // DMA model: goes busy the cycle after the start write, busy for HOLD cycles
  initial begin
    bus.dma_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        bus.dma_busy = 1'b0;
        pending = 1'b0;
      end else begin
        if (dma_force) begin
          bus.dma_busy = 1'b1;
          hold_left = 1;
        end else if (pending) begin
          bus.dma_busy = 1'b1;
          hold_left = HOLD;
          pending = 1'b0;
        end else if (bus.dma_busy) begin
          hold_left = hold_left - 1;
          if (hold_left <= 0) bus.dma_busy = 1'b0;
        end
        if (dma_auto && bus.dma_write && bus.dma_select == 3'd3) pending = 1'b1;
      end
    end
  end

  function automatic string kname(input int k);
    case (k)
      K_READY: kname = "ready";
      K_WRITE: kname = "write";
      K_DONE:  kname = "done";
      default: kname = "err";
    endcase
  endfunction

  task automatic observe(input int kind, input int val);
    exp_t e;
    int   gap;
    gap = cyc - last_ev_cyc;
    last_ev_cyc = cyc;
    total_cnt++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected_%s: got val=%0h at cycle %0d, required no event", kname(kind), val, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind == kind && e.val == val && (e.gap < 0 || e.gap == gap)) begin
        pass_cnt++;
      end else begin
        $display("FAIL %s: got %s val=%0h gap=%0d, required %s val=%0h gap=%0d",
                 kname(e.kind), kname(kind), val, gap, kname(e.kind), e.val, e.gap);
      end
    end
  endtask

  // Monitor: every output pulse is matched against the head of the queue
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.req_ready != 2'b00)
        observe(K_READY, int'(bus.ctl_busy) * 256 + int'(bus.grant_id) * 16 + int'(bus.req_ready));
      if (bus.dma_write)
        observe(K_WRITE, int'(bus.dma_select) * 256 + int'(bus.dma_data));
      if (bus.job_done != 2'b00) observe(K_DONE, int'(bus.job_done));
      if (bus.job_err != 2'b00) observe(K_ERR, int'(bus.job_err));
    end
  end

  task automatic push(input int kind, input int val, input int gap);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    e.gap  = gap;
    exp_q.push_back(e);
  endtask

  task automatic push_ready(input int id);
    push(K_READY, 256 + id * 16 + (1 << id), -1);
  endtask

  task automatic push_writes(input int cols, input int rows, input int set, input int addr);
    push(K_WRITE, 0 * 256 + cols, 1);
    push(K_WRITE, 1 * 256 + rows, 1);
    push(K_WRITE, 2 * 256 + set, 1);
    push(K_WRITE, 4 * 256 + addr, 1);
    push(K_WRITE, 3 * 256 + 1, 1);
  endtask

  task automatic push_ok(input int id, input int cols, input int rows, input int set, input int addr);
    push_ready(id);
    push_writes(cols, rows, set, addr);
    push(K_DONE, 1 << id, HOLD + 2);
  endtask

  task automatic push_bad(input int id);
    push_ready(id);
    push(K_ERR, 1 << id, 1);
  endtask

  task automatic set_fields(input int id, input int cols, input int rows, input int set, input int addr);
    bus.req_cols[id*DW +: DW] = cols[DW-1:0];
    bus.req_rows[id*DW +: DW] = rows[DW-1:0];
    bus.req_addr[id*DW +: DW] = addr[DW-1:0];
    bus.req_set[id*2 +: 2]    = set[1:0];
  endtask

  task automatic check(input string name, input int got, input int want);
    total_cnt++;
    if (got == want) pass_cnt++;
    else $display("FAIL %s: got %0h, required %0h", name, got, want);
  endtask

  task automatic check_idle(input string name);
    int v;
    v = int'(bus.req_ready) | (int'(bus.job_done) << 2) | (int'(bus.job_err) << 4) |
        (int'(bus.dma_write) << 6) | (int'(bus.dma_select) << 7) | (int'(bus.dma_data) << 10) |
        (int'(bus.ctl_busy) << 18) | (int'(bus.grant_id) << 19);
    check(name, v, 0);
  endtask

  task automatic bound_fail(input string name);
    total_cnt++;
    $display("FAIL %s: timed out waiting, required event did not occur", name);
  endtask

  // Hold one requester valid until its req_ready, then withdraw it
  task automatic request(input int id);
    int t;
    t = 0;
    bus.req_valid[id] = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.req_ready[id] && t < 60);
    if (!bus.req_ready[id]) bound_fail("request_ready");
    bus.req_valid[id] = 1'b0;
  endtask

  // Hold both requesters valid across n acceptances
  task automatic serve_both(input int n);
    int seen;
    int t;
    seen = 0;
    t = 0;
    bus.req_valid = 2'b11;
    while (seen < n && t < 300) begin
      @(negedge clk);
      t++;
      if (bus.req_ready != 2'b00) seen++;
    end
    bus.req_valid = 2'b00;
    if (seen < n) bound_fail("serve_both");
  endtask

  task automatic wait_idle(input int limit);
    int t;
    t = 0;
    while ((bus.ctl_busy || exp_q.size() != 0) && t < limit) begin
      @(negedge clk);
      t++;
    end
    if (bus.ctl_busy || exp_q.size() != 0) bound_fail("wait_idle");
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = 2'b00;
    bus.req_cols  = '0;
    bus.req_rows  = '0;
    bus.req_set   = 4'd0;
    bus.req_addr  = '0;
    repeat (3) @(negedge clk);
    check_idle("reset_outputs");
    rst = 1'b0;
    @(negedge clk);

    // Contention after reset, both held: 0, 1, 0; job 0 is the reference job
    set_fields(0, 2, 3, 1, 8'h10);
    set_fields(1, 1, 1, 2, 8'h20);
    push_ok(0, 2, 3, 1, 8'h10);
    push_ok(1, 1, 1, 2, 8'h20);
    push_ok(0, 2, 3, 1, 8'h10);
    serve_both(3);
    wait_idle(200);

    // Zero rows and zero cols are rejected without writes
    set_fields(1, 4, 0, 0, 8'h00);
    push_bad(1);
    request(1);
    wait_idle(50);
    set_fields(0, 0, 7, 3, 8'h05);
    push_bad(0);
    request(0);
    wait_idle(50);

    // No acceptance while the DMA is busy; a withdrawn request is dropped
    dma_force = 1'b1;
    repeat (2) @(negedge clk);
    bus.req_valid[1] = 1'b1;
    repeat (5) @(negedge clk);
    check("busy_blocks_accept", int'(bus.ctl_busy), 0);
    bus.req_valid[1] = 1'b0;
    dma_force = 1'b0;
    repeat (4) @(negedge clk);
    check("withdrawn_not_served", int'(bus.ctl_busy), 0);

    // ARM timeout: DMA never goes busy
    dma_auto = 1'b0;
    set_fields(1, 3, 3, 2, 8'h40);
    push_ready(1);
    push_writes(3, 3, 2, 8'h40);
    push(K_ERR, 2, TO + 1);
    request(1);
    wait_idle(200);
    dma_auto = 1'b1;

    // Address range boundary: end 0x103 rejected, end 0xFF accepted
    set_fields(0, 4, 5, 0, 8'hF0);
    push_bad(0);
    request(0);
    wait_idle(50);
    set_fields(0, 4, 5, 3, 8'hEC);
    push_ok(0, 4, 5, 3, 8'hEC);
    request(0);
    wait_idle(100);

    // Reset while RUN: outputs clear, no done, requester 0 wins afterwards
    set_fields(0, 1, 2, 0, 8'h30);
    push_ready(0);
    push_writes(1, 2, 0, 8'h30);
    request(0);
    begin
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (exp_q.size() != 0) bound_fail("run_writes");
    end
    repeat (2) @(negedge clk);
    check("busy_in_run", int'(bus.ctl_busy), 1);
    rst = 1'b1;
    @(negedge clk);
    check_idle("reset_in_run");
    rst = 1'b0;
    repeat (HOLD + 3) @(negedge clk);
    check("aborted_job_idle", int'(bus.ctl_busy), 0);

    set_fields(0, 2, 2, 1, 8'h50);
    set_fields(1, 3, 1, 0, 8'h60);
    push_ok(0, 2, 2, 1, 8'h50);
    push_ok(1, 3, 1, 0, 8'h60);
    serve_both(2);
    wait_idle(200);

    while (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      total_cnt++;
      $display("FAIL missing_%s: got nothing, required val=%0h", kname(e.kind), e.val);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/dma_job_arbiter.md
DMA_JOB_ARBITER -- requirements
Module: dma_job_arbiter

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 8, meaning the width of DMA register data, addresses and dimensions.
REQ-002 SHALL have parameter ARM_TIMEOUT, default 255, meaning the maximum number of cycles to wait for dma_busy after the start write.
REQ-003 SHALL have port clk  input  1  clock; reset rst, synchronous, active-high; clock clk.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port req_valid  input  2  job request, one bit per requester, held until req_ready.
REQ-006 SHALL have port req_cols  input  2*DATAWIDTH  column dimension; requester i uses bits [i*DATAWIDTH +: DATAWIDTH].
REQ-007 SHALL have port req_rows  input  2*DATAWIDTH  row dimension, packed as for req_cols.
REQ-008 SHALL have port req_set  input  4  tensor set (A=0, B=1, X=2, W=3); requester i uses bits [2i+1:2i].
REQ-009 SHALL have port req_addr  input  2*DATAWIDTH  start address, packed as for req_cols.
REQ-010 SHALL have port req_ready  output  2  one-cycle accept pulse per requester.
REQ-011 SHALL have port job_done  output  2  one-cycle completion pulse per requester.
REQ-012 SHALL have port job_err  output  2  one-cycle error pulse per requester.
REQ-013 SHALL have port dma_write  output  1  DMA register write strobe.
REQ-014 SHALL have port dma_data  output  DATAWIDTH  DMA register write data.
REQ-015 SHALL have port dma_select  output  3  DMA register index.
REQ-016 SHALL have port dma_busy  input  1  DMA busy flag.
REQ-017 SHALL have port ctl_busy  output  1  high whenever the state is not IDLE.
REQ-018 SHALL have port grant_id  output  1  requester currently owning the DMA, valid while ctl_busy is high.

Function
REQ-019 SHALL implement states IDLE, LOAD, ARM, RUN, DONE and ERR; all outputs SHALL be registered.
REQ-020 In IDLE with dma_busy=0, SHALL accept one requester: a single valid requester wins; when both are valid, the requester not granted last wins (round-robin).
REQ-021 SHALL make no acceptance in IDLE while dma_busy=1.
REQ-022 At acceptance cycle T, SHALL pulse req_ready[i] during T, latch that requester's cols/rows/set/addr at T, and set grant_id=i.
REQ-023 Validity check at T: cols=0, rows=0, or addr+rows*cols-1 exceeding 2^DATAWIDTH-1 (computed at 2*DATAWIDTH+1 bits) SHALL go to ERR with no DMA writes.
REQ-024 LOAD SHALL assert dma_write for exactly 5 consecutive cycles T+1..T+5 with (select,data) = (0,cols), (1,rows), (2,zero-extended set), (4,addr), (3,1), in that order; dma_write SHALL be 0 at all other times.
REQ-025 ARM SHALL wait for dma_busy=1, then move to RUN; after ARM_TIMEOUT cycles without dma_busy it SHALL move to ERR.
REQ-026 RUN SHALL wait for dma_busy=0, then move to DONE.
REQ-027 DONE SHALL last 1 cycle, pulse job_done[grant_id], record grant_id as last granted, and return to IDLE.
REQ-028 ERR SHALL last 1 cycle, pulse job_err[grant_id], record grant_id as last granted, and return to IDLE.
REQ-029 A new acceptance SHALL occur no earlier than the cycle after DONE or ERR.
REQ-030 A req_valid deasserted before req_ready SHALL be treated as withdrawn; req_valid changes after acceptance SHALL be ignored.
REQ-031 The ARM timeout counter SHALL be sized to hold ARM_TIMEOUT and SHALL clear on entry to ARM.

Reset
REQ-032 On rst, SHALL go to IDLE and drive req_ready, job_done, job_err, dma_write, dma_data, dma_select, ctl_busy and grant_id to 0.
REQ-033 On rst, the round-robin pointer SHALL be set so that requester 0 wins the first contention.
REQ-034 rst asserted mid-job SHALL abort the job with no done/err pulse; the DMA shares the same rst.

Verification
REQ-035 Single job: req0 with cols=2, rows=3, set=1, addr=0x10 -> req_ready[0] at T; writes (0,2), (1,3), (2,1), (4,0x10), (3,1) at T+1..T+5; job_done[0] one cycle after dma_busy falls.
REQ-036 Contention: both valid after reset -> req0 served first, then req1; with both held valid, service alternates 0,1,0.
REQ-037 Zero size: req1 with rows=0 -> req_ready[1], job_err[1] next cycle, no dma_write.
REQ-038 Overflow: addr=0xF0, cols=4, rows=5 (end 0x103) -> job_err, no writes; addr=0xEC, same dims (end 0xFF) -> accepted.
REQ-039 Timeout: dma_busy held 0 after the start write -> job_err exactly ARM_TIMEOUT cycles after ARM entry.
REQ-040 Reset in RUN: rst pulse -> all outputs 0 the next cycle, no job_done, and req0 wins the next contention.
